// File: rtl/fifo_buffer_pkg.sv
// Shared defaults for the demux lane FIFOs: word width, pointer width and fill thresholds.
// The demux imports the same word width so both ends of a lane always agree.
package fifo_buffer_pkg;

  localparam int unsigned DefDataWidth     = 6;
  localparam int unsigned DefAddrWidth     = 2;
  localparam int unsigned DefAlmostFullTh  = 3;
  localparam int unsigned DefAlmostEmptyTh = 1;

  // Encodes which of the two ports completed a transfer in a cycle.
  typedef enum logic [1:0] {
    XferNone  = 2'b00,
    XferRead  = 2'b01,
    XferWrite = 2'b10,
    XferBoth  = 2'b11
  } xfer_e;

endpackage

// File: rtl/fifo_buffer_mem.sv
// Register-array storage for fifo_buffer: enabled synchronous write, registered read with enable.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage is deliberately not reset; only the visible read register is.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_buffer.sv
// Single-clock lane FIFO with registered pop data, fill-level flags and a sticky error flag.
// Pointers, count, flags and error live here; storage is in fifo_mem.
module fifo_buffer
  import fifo_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DefDataWidth,
  parameter int unsigned ADDR_WIDTH      = DefAddrWidth,
  parameter int unsigned ALMOST_FULL_TH  = DefAlmostFullTh,
  parameter int unsigned ALMOST_EMPTY_TH = DefAlmostEmptyTh
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int unsigned       Depth    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DepthCnt = Depth[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AfTh     = ALMOST_FULL_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AeTh     = ALMOST_EMPTY_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CntOne   = 1;
  localparam logic [ADDR_WIDTH-1:0] PtrOne   = 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  valid_q;
  logic                  error_q, error_d;
  logic                  wr_acc, rd_acc;
  logic                  overflow, underflow;
  xfer_e                 xfer;

  // Flags decode only the registered count.
  always_comb begin
    full         = (count_q == DepthCnt);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AfTh);
    almost_empty = (count_q <= AeTh);
  end

  // A pop at full frees the slot the push lands in; a pop at empty never bypasses a push.
  always_comb begin
    wr_acc    = push && (!full || pop);
    rd_acc    = pop && !empty;
    overflow  = push && full && !pop;
    underflow = pop && empty;
    xfer      = xfer_e'({wr_acc, rd_acc});
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = error_q | overflow | underflow;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    unique case (xfer)
      XferWrite: count_d = count_q + CntOne;
      XferRead:  count_d = count_q - CntOne;
      default:   count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= rd_acc;
      error_q  <= error_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_acc && !reset),
    .wr_addr(wr_ptr_q),
    .wr_data(data_in),
    .rd_en  (rd_acc && !reset),
    .rd_addr(rd_ptr_q),
    .rd_data(data_out)
  );

  assign valid_out = valid_q;
  assign count     = count_q;
  assign error     = error_q;

endmodule
